// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU pipeline owns the memory port combinationally
// in IDLE; a debug/result-dump requester borrows it for LAT cycles once the
// CPU is quiet or the debug side has been denied for STARVE_MAX cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CPU drives memory with zero latency, debug requests may wait
// DBG   | latched debug access owns memory for LAT cycles, CPU stalls
module dmem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DBG  = 1'b1
    } state_t;

    // Occupancy is a down-counter: loaded with LAT-1 on grant, the access
    // finishes on the edge where it reads zero.
    localparam logic [3:0] OCC_LOAD   = 4'(LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  occ_q, occ_d;
    logic [3:0]  starve_q, starve_d;
    logic        lat_we_q, lat_we_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_ack_q, dbg_ack_d;

    logic        cpu_req;
    logic        grant;

    assign cpu_req = cpu_re | cpu_we;
    assign grant   = dbg_req & (~cpu_req | (starve_q == STARVE_LIM));

    // Memory port steering: CPU passthrough in IDLE, latched debug access in DBG.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re & ~cpu_we;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        if (state_q == ST_DBG) begin
            mem_addr  = lat_addr_q;
            mem_wdata = lat_wdata_q;
            mem_we    = lat_we_q;
            mem_re    = ~lat_we_q;
            cpu_rdata = 32'h0;
            cpu_stall = cpu_req;
        end
    end

    // Next-state, counters, request latch and debug completion.
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        starve_d    = starve_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d     = ST_DBG;
                    occ_d       = OCC_LOAD;
                    starve_d    = 4'd0;
                    lat_we_d    = dbg_we;
                    lat_addr_d  = dbg_addr;
                    lat_wdata_d = dbg_wdata;
                end else if (dbg_req) begin
                    // only reachable with cpu_req=1: debug was denied this cycle
                    if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    starve_d = 4'd0;
                end
            end
            ST_DBG: begin
                starve_d = 4'd0;
                if (occ_q == 4'd0) begin
                    state_d   = ST_IDLE;
                    dbg_ack_d = 1'b1;
                    if (!lat_we_q) begin
                        dbg_rdata_d = mem_rdata;
                    end
                end else begin
                    occ_d = occ_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any debug access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            occ_q       <= 4'd0;
            starve_q    <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'h0;
            lat_wdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
            dbg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            starve_q    <= starve_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_ack_q   <= dbg_ack_d;
        end
    end

    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: each stimulus cycle pushes the expected
// outputs computed by a transaction-level model; a negedge monitor pops and
// compares. Directed scenarios first, then randomized traffic with resets.
module tb_dmem_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;

    dmem_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT, written by whatever the DUT drives.
    logic [31:0] tb_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct packed {
        logic        stall;
        logic [31:0] crd;
        logic        mre;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        ack;
        logic [31:0] drd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: memory image, pending debug transaction and wait count.
    logic [31:0] model_mem [0:255];
    int          m_left  = 0;
    int          m_wait  = 0;
    logic        m_ack   = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_twe   = 1'b0;
    logic [31:0] m_taddr = 32'h0;
    logic [31:0] m_twd   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, mon_e.stall});
            chk("cpu_rdata", cpu_rdata, mon_e.crd);
            chk("mem_re",    {31'b0, mem_re},    {31'b0, mon_e.mre});
            chk("mem_we",    {31'b0, mem_we},    {31'b0, mon_e.mwe});
            chk("mem_addr",  mem_addr,  mon_e.maddr);
            chk("mem_wdata", mem_wdata, mon_e.mwd);
            chk("dbg_ack",   {31'b0, dbg_ack},   {31'b0, mon_e.ack});
            chk("dbg_rdata", dbg_rdata, mon_e.drd);
        end
    end

    // One clock cycle of stimulus: drive inputs, predict outputs, advance model.
    task automatic cycle(input logic rst, input logic cre, input logic cwe,
                         input logic [31:0] ca, input logic [31:0] cw,
                         input logic dreq, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dw);
        exp_t e;
        int   ci;
        int   ti;
        @(posedge clk);
        #1;
        reset_n = rst; cpu_re = cre; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dw;
        ci = int'(ca[9:2]);
        ti = int'(m_taddr[9:2]);
        e.crd = 32'h0;
        if (!rst) begin
            m_left = 0; m_wait = 0; m_ack = 1'b0; m_rdata = 32'h0;
            m_twe = 1'b0; m_taddr = 32'h0; m_twd = 32'h0;
            e.stall = 1'b0; e.crd = model_mem[ci]; e.mre = cre & ~cwe; e.mwe = cwe;
            e.maddr = ca; e.mwd = cw; e.ack = 1'b0; e.drd = 32'h0;
            if (cwe) model_mem[ci] = cw;
        end else begin
            e.ack = m_ack;
            e.drd = m_rdata;
            m_ack = 1'b0;
            if (m_left > 0) begin
                e.stall = cre | cwe; e.crd = 32'h0;
                e.mre = ~m_twe; e.mwe = m_twe; e.maddr = m_taddr; e.mwd = m_twd;
                if (m_left == 1) begin
                    if (!m_twe) m_rdata = model_mem[ti];
                    m_ack = 1'b1;
                end
                if (m_twe) model_mem[ti] = m_twd;
                m_left--;
            end else begin
                e.stall = 1'b0; e.crd = model_mem[ci];
                e.mre = cre & ~cwe; e.mwe = cwe; e.maddr = ca; e.mwd = cw;
                if (cwe) model_mem[ci] = cw;
                if (dreq && (!(cre | cwe) || m_wait == STARVE_MAX)) begin
                    m_twe = dwe; m_taddr = da; m_twd = dw;
                    m_left = LAT; m_wait = 0;
                end else if (dreq) begin
                    if (m_wait < STARVE_MAX) m_wait++;
                end else begin
                    m_wait = 0;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
            model_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
        end
        reset_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;

        // Reset held, then released.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(2);

        // CPU-only writes, then preload 0x1234 at 0x20.
        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'hA5, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);

        // Debug-only read of 0x20.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        idle(5);

        // Contention: CPU read and debug read both held.
        for (int i = 0; i < 14; i++)
            cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        idle(3);

        // Debug write dropped after grant, with junk on latched inputs, then CPU reads it back.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'hDEAD);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h44, 32'hFFFF);
        idle(4);
        cycle(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during the first DBG cycle of a debug write.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hBEEF);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hBEEF);
        idle(4);
        cycle(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  32'($urandom_range(0, 15)) << 2, $urandom,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  32'($urandom_range(0, 15)) << 2, $urandom);
        end
        idle(4);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
